// File: rtl/round_controller.sv
// rtl/round_controller.sv - game-round sequencer driving the score comparator/subtractor
module round_controller #(
    parameter int                 WIDTH         = 5,
    parameter int                 SCORE_WIDTH   = 8,
    parameter logic [WIDTH-1:0]   LFSR_SEED     = 5'b00001,
    parameter int                 REVEAL_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   start,
    input  logic                   pick_valid,
    input  logic [WIDTH-1:0]       pick,
    output logic                   pick_ready,
    output logic [WIDTH-1:0]       x,
    output logic [WIDTH-1:0]       y,
    input  logic                   lose,
    input  logic [WIDTH-1:0]       bonus,
    output logic [WIDTH-1:0]       rng,
    output logic [SCORE_WIDTH-1:0] score,
    output logic [3:0]             rounds,
    output logic                   busy,
    output logic                   game_over
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WAIT_PICK = 3'd1;
    localparam logic [2:0] S_DRAW      = 3'd2;
    localparam logic [2:0] S_EVAL      = 3'd3;
    localparam logic [2:0] S_REVEAL    = 3'd4;
    localparam logic [2:0] S_OVER      = 3'd5;

    localparam int CW = (REVEAL_CYCLES > 1) ? $clog2(REVEAL_CYCLES) : 1;

    logic [2:0]             state;
    logic [2:0]             next_state;
    logic [WIDTH-1:0]       lfsr;
    logic [CW-1:0]          reveal_cnt;
    logic [SCORE_WIDTH:0]   score_sum;

    assign rng = lfsr;

    // One extra bit on the sum exposes overflow for saturation.
    assign score_sum = {1'b0, score} + {{(SCORE_WIDTH + 1 - WIDTH){1'b0}}, bonus};

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:      if (start) next_state = S_WAIT_PICK;
            S_WAIT_PICK: if (pick_valid && pick_ready) next_state = S_DRAW;
            S_DRAW:      next_state = S_EVAL;
            S_EVAL:      next_state = lose ? S_OVER : S_REVEAL;
            S_REVEAL:    if (reveal_cnt == '0) next_state = S_WAIT_PICK;
            S_OVER:      if (start) next_state = S_WAIT_PICK;
            default:     next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            lfsr       <= LFSR_SEED;
            reveal_cnt <= '0;
            x          <= '0;
            y          <= '0;
            score      <= '0;
            rounds     <= '0;
            pick_ready <= 1'b0;
            busy       <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            state      <= next_state;
            lfsr       <= {lfsr[WIDTH-2:0], lfsr[4] ^ lfsr[2]};
            // Status flags are registered from the next state so they line up with it.
            pick_ready <= (next_state == S_WAIT_PICK);
            busy       <= (next_state == S_WAIT_PICK) || (next_state == S_DRAW) ||
                          (next_state == S_EVAL) || (next_state == S_REVEAL);
            game_over  <= (next_state == S_OVER);

            case (state)
                S_IDLE: begin
                    if (start) begin
                        score  <= '0;
                        rounds <= '0;
                    end
                end
                S_WAIT_PICK: begin
                    if (pick_valid && pick_ready) x <= pick;
                end
                S_DRAW: begin
                    y <= lfsr;
                end
                S_EVAL: begin
                    if (!lose) begin
                        score      <= score_sum[SCORE_WIDTH] ? '1 : score_sum[SCORE_WIDTH-1:0];
                        rounds     <= (rounds == 4'hF) ? rounds : rounds + 4'd1;
                        reveal_cnt <= CW'(REVEAL_CYCLES - 1);
                    end
                end
                S_REVEAL: begin
                    if (reveal_cnt != '0) reveal_cnt <= reveal_cnt - 1'b1;
                end
                S_OVER: begin
                    if (start) begin
                        score  <= '0;
                        rounds <= '0;
                        x      <= '0;
                        y      <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_round_controller.sv
// tb/tb_round_controller.sv - directed self-checking bench for round_controller
module tb_round_controller;

    logic       clk = 1'b0;
    logic       resetn;
    logic       start;
    logic       pick_valid;
    logic [4:0] pick;
    logic       pick_ready;
    logic [4:0] x;
    logic [4:0] y;
    logic       lose;
    logic [4:0] bonus;
    logic [4:0] rng;
    logic [7:0] score;
    logic [3:0] rounds;
    logic       busy;
    logic       game_over;

    int checks = 0;
    int errors = 0;

    logic [4:0] m_lfsr;
    logic [4:0] exp_y;
    logic [4:0] lfsr_tab [0:6];

    round_controller dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .pick_valid (pick_valid),
        .pick       (pick),
        .pick_ready (pick_ready),
        .x          (x),
        .y          (y),
        .lose       (lose),
        .bonus      (bonus),
        .rng        (rng),
        .score      (score),
        .rounds     (rounds),
        .busy       (busy),
        .game_over  (game_over)
    );

    always #5 clk = ~clk;

    // Reference LFSR: x^5 + x^3 + 1 shift-left form, seeded with 1.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) m_lfsr <= 5'b00001;
        else         m_lfsr <= {m_lfsr[3:0], m_lfsr[4] ^ m_lfsr[2]};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic play(input logic [4:0] p, input logic l, input logic [4:0] b);
        pick_valid = 1'b1; pick = p; lose = l; bonus = b;
        tick();
        pick_valid = 1'b0;
        tick();
        tick();
        lose = 1'b0; bonus = '0;
        if (!l) repeat (4) tick();
    endtask

    initial begin
        lfsr_tab[0] = 5'b00001; lfsr_tab[1] = 5'b00010; lfsr_tab[2] = 5'b00100;
        lfsr_tab[3] = 5'b01001; lfsr_tab[4] = 5'b10010; lfsr_tab[5] = 5'b00101;
        lfsr_tab[6] = 5'b01011;
        resetn = 1'b0; start = 1'b0; pick_valid = 1'b0; pick = '0; lose = 1'b0; bonus = '0;
        repeat (2) tick();
        check("rst_score", 32'(score), 32'd0);
        check("rst_rounds", 32'(rounds), 32'd0);
        check("rst_ready", 32'(pick_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_over", 32'(game_over), 32'd0);
        check("rst_xy", 32'({x, y}), 32'd0);
        resetn = 1'b1;

        // LFSR sequence and period
        for (int i = 0; i < 7; i++) begin
            check($sformatf("lfsr_%0d", i), 32'(rng), 32'(lfsr_tab[i]));
            tick();
        end
        repeat (24) tick();
        check("lfsr_period", 32'(rng), 32'd1);

        // Won round: pick 3, bonus 7
        start = 1'b1; tick(); start = 1'b0;
        check("ready_wait", 32'(pick_ready), 32'd1);
        check("busy_wait", 32'(busy), 32'd1);
        pick_valid = 1'b1; pick = 5'd3; lose = 1'b0; bonus = 5'd7;
        tick();
        pick_valid = 1'b0;
        check("x_draw", 32'(x), 32'd3);
        check("ready_draw", 32'(pick_ready), 32'd0);
        exp_y = m_lfsr;
        tick();
        check("y_eval", 32'(y), 32'(exp_y));
        check("score_eval", 32'(score), 32'd0);
        tick();
        lose = 1'b0; bonus = '0;
        check("score_r1", 32'(score), 32'd7);
        check("rounds_r1", 32'(rounds), 32'd1);
        repeat (3) tick();
        check("ready_reveal4", 32'(pick_ready), 32'd0);
        tick();
        check("ready_after_reveal", 32'(pick_ready), 32'd1);

        // Ignored start during DRAW/REVEAL and lose during REVEAL
        pick_valid = 1'b1; pick = 5'd10; bonus = 5'd2;
        tick();
        pick_valid = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        bonus = '0;
        check("score_r2", 32'(score), 32'd9);
        check("rounds_r2", 32'(rounds), 32'd2);
        start = 1'b1; lose = 1'b1;
        tick(); tick();
        check("ign_ready", 32'(pick_ready), 32'd0);
        check("ign_score", 32'(score), 32'd9);
        check("ign_over", 32'(game_over), 32'd0);
        start = 1'b0; lose = 1'b0;
        tick(); tick();
        check("ign_ready_back", 32'(pick_ready), 32'd1);

        // Loss
        play(5'd7, 1'b1, 5'd20);
        check("loss_over", 32'(game_over), 32'd1);
        check("loss_score", 32'(score), 32'd9);
        check("loss_busy", 32'(busy), 32'd0);
        pick_valid = 1'b1; pick = 5'd5;
        tick(); tick();
        pick_valid = 1'b0;
        check("over_x", 32'(x), 32'd7);
        check("over_ready", 32'(pick_ready), 32'd0);
        check("over_rounds", 32'(rounds), 32'd2);
        start = 1'b1; tick(); start = 1'b0;
        check("restart_score", 32'(score), 32'd0);
        check("restart_rounds", 32'(rounds), 32'd0);
        check("restart_xy", 32'({x, y}), 32'd0);
        check("restart_ready", 32'(pick_ready), 32'd1);
        check("restart_over", 32'(game_over), 32'd0);

        // Saturation
        for (int r = 1; r <= 16; r++) begin
            play(5'd1, 1'b0, 5'd31);
            if (r == 8)  check("sat_score8", 32'(score), 32'd248);
            if (r == 10) check("sat_score10", 32'(score), 32'd255);
        end
        check("sat_rounds", 32'(rounds), 32'd15);
        check("sat_score16", 32'(score), 32'd255);

        // Reset during EVAL
        pick_valid = 1'b1; pick = 5'd4; bonus = 5'd5;
        tick();
        pick_valid = 1'b0;
        tick();
        resetn = 1'b0;
        #1;
        check("mid_score", 32'(score), 32'd0);
        check("mid_xy", 32'({x, y}), 32'd0);
        check("mid_rng", 32'(rng), 32'd1);
        check("mid_busy", 32'(busy), 32'd0);
        tick();
        resetn = 1'b1;
        bonus = '0;
        tick(); tick();
        check("post_score", 32'(score), 32'd0);
        check("post_rounds", 32'(rounds), 32'd0);
        check("post_busy", 32'(busy), 32'd0);
        check("post_rng", 32'(rng), 32'(m_lfsr));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/round_controller.md
Name: round_controller

Overview:
Game-round sequencer that drives the operand side of the score comparator/subtractor and consumes its results. It accepts the player's 5-bit pick and draws a machine pick from an internal LFSR. It presents both to the comparator as x/y, samples lose/bonus, accumulates score and counts rounds. It sits between the player input debouncer and the comparator/subtractor, and owns game start/over sequencing.

Parameters:
WIDTH, 5, operand width of x, y, pick, bonus
SCORE_WIDTH, 8, accumulated score width
LFSR_SEED, 5'b00001, LFSR value loaded at reset; must be non-zero
REVEAL_CYCLES, 4, cycles both picks are held visible after a won round (>=1)

Ports:
clk  in  1  system clock, rising edge
resetn  in  1  asynchronous, active-low reset
start  in  1  pulse: begin a new game
pick_valid  in  1  player pick offered
pick  in  WIDTH  player pick value
pick_ready  out  1  controller accepts pick this cycle
x  out  WIDTH  player operand to comparator
y  out  WIDTH  machine operand to comparator
lose  in  1  comparator result: picks equal
bonus  in  WIDTH  subtractor result |x-y|
rng  out  WIDTH  current LFSR state (debug/test)
score  out  SCORE_WIDTH  accumulated bonus
rounds  out  4  won rounds in current game
busy  out  1  high in WAIT_PICK..REVEAL
game_over  out  1  high in OVER

Behaviour:
- Reset (async, resetn=0): state=IDLE; x=y=0; score=0; rounds=0; pick_ready=0; busy=0; game_over=0; LFSR=LFSR_SEED; reveal counter=0. Reset mid-round aborts the round with no score update.
- LFSR: free-running, advances every clock after reset, including IDLE. next = {lfsr[3:0], lfsr[4]^lfsr[2]}. Period 31, never zero.
- States: IDLE, WAIT_PICK, DRAW, EVAL, REVEAL, OVER.
- IDLE: start=1 -> clear score/rounds, go to WAIT_PICK.
- WAIT_PICK: pick_ready=1 (registered, high exactly in this state). On pick_valid&&pick_ready: x<=pick, go to DRAW. pick_valid outside WAIT_PICK is ignored.
- DRAW (1 cycle): y<=rng (value of LFSR in this cycle), go to EVAL.
- EVAL (1 cycle): x/y stable for a full cycle; lose/bonus sampled at the end of EVAL.
  - lose=1 -> OVER.
  - else score<=score+bonus, saturating at 2^SCORE_WIDTH-1; rounds<=rounds+1, saturating at 15; counter<=REVEAL_CYCLES-1; go to REVEAL.
- REVEAL: hold x/y; decrement counter; at 0 go to WAIT_PICK. Total REVEAL dwell = REVEAL_CYCLES cycles.
- OVER: game_over=1; x, y, score and rounds frozen. start=1 -> clear score/rounds, x=y=0, go to WAIT_PICK.
- start in WAIT_PICK/DRAW/EVAL/REVEAL is ignored.
- lose/bonus are ignored in every state except EVAL.
- Latency: pick handshake cycle N -> y updated N+1 -> score/rounds/game_over visible N+3.
- Widths: bonus is zero-extended to SCORE_WIDTH before the add. Saturation is detected with a one-bit-wider sum.

Test Plan:
- LFSR: release reset, start=0 -> rng sequence 00001, 00010, 00100, 01001, 10010, 00101, 01011; rng returns to 00001 after 31 cycles.
- Won round: start; pick=3 with pick_valid; bench stub drives lose=0, bonus=7 in EVAL -> 3 cycles after handshake score=7, rounds=1; REVEAL lasts 4 cycles; pick_ready re-asserts.
- Loss: after one won round (score=7), stub drives lose=1 in EVAL -> game_over=1, score stays 7, pick_valid ignored; start -> score=0, rounds=0, pick_ready=1.
- Saturation: SCORE_WIDTH=8, 10 won rounds with bonus=31 -> score=255 (not 54); 16 won rounds -> rounds stays 15.
- Ignored inputs: start pulsed during DRAW/REVEAL and lose=1 driven during REVEAL -> no state change, score unchanged.
- Reset mid-op: assert resetn=0 during EVAL with bonus=5 -> immediately score=0, x=y=0, IDLE, rng=00001; no increment after release.
